// File: rtl/recip_pkg.sv
// Shared defaults for the integer reciprocal datapath: operand width, iteration
// count, the core latency rule and the divide-by-zero saturation value.
package recip_pkg;

  localparam int NUMBER_WIDTH_DEF = 24;
  localparam int ITERATIONS_DEF   = 2;
  localparam int TAG_WIDTH_DEF    = 8;
  localparam int FIFO_DEPTH_DEF   = 16;

  function automatic int recip_latency(input int iterations);
    return 7 + 3 * iterations;
  endfunction

  localparam int LATENCY_DEF = recip_latency(ITERATIONS_DEF);

  localparam logic [2*NUMBER_WIDTH_DEF-1:0] DIV0_SAT_DEF = {(2*NUMBER_WIDTH_DEF){1'b1}};

endpackage

// File: rtl/recip_result_fifo.sv
// First-word-fall-through result FIFO with a write-through path so an item
// arriving at an empty FIFO is visible in the same cycle it is captured.
module recip_result_fifo #(
  parameter int WIDTH = 57,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             empty_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;

  assign empty_s    = (wr_ptr_q == rd_ptr_q);
  assign full_s     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A write consumed in the same cycle through the bypass never touches storage.
  assign push_s     = wr_en_i & ~(empty_s & rd_en_i);
  assign pop_s      = rd_en_i & ~empty_s;
  assign rd_valid_o = ~empty_s | wr_en_i;

  always_comb begin
    rd_data_o = '0;
    if (!empty_s) begin
      rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
    end else if (wr_en_i) begin
      rd_data_o = wr_data_i;
    end else begin
      rd_data_o = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  recip_result_fifo_chk u_chk (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en_i (wr_en_i),
    .full_i  (full_s)
  );

endmodule

// File: rtl/recip_result_fifo_chk.sv
// Protocol checker for the result FIFO: the credit scheme must make a write
// into a full FIFO impossible.
module recip_result_fifo_chk (
  input logic clk,
  input logic resetn,
  input logic wr_en_i,
  input logic full_i
);

  a_no_write_when_full: assert property (@(posedge clk) disable iff (!resetn)
    !(wr_en_i && full_i));

endmodule

// File: rtl/recip_stream_ctrl.sv
// Valid/ready wrapper around the ce-pipelined reciprocal core: credit-limited
// intake, valid/tag/div0 tracking alongside the core, and a result FIFO.
module recip_stream_ctrl
  import recip_pkg::*;
#(
  parameter int NUMBER_WIDTH = NUMBER_WIDTH_DEF,
  parameter int LATENCY      = LATENCY_DEF,
  parameter int TAG_WIDTH    = TAG_WIDTH_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [NUMBER_WIDTH-1:0]   s_data,
  input  logic [TAG_WIDTH-1:0]      s_tag,
  output logic                      core_ce,
  output logic [NUMBER_WIDTH-1:0]   core_in,
  input  logic [2*NUMBER_WIDTH-1:0] core_out,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [2*NUMBER_WIDTH-1:0] m_data,
  output logic [TAG_WIDTH-1:0]      m_tag,
  output logic                      m_div0
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int RES_W = 2 * NUMBER_WIDTH;
  localparam int ENT_W = RES_W + TAG_WIDTH + 1;

  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic                 s_ready_q;
  logic [LATENCY-1:0]   vld_sr_q;
  logic [LATENCY-1:0]   div0_sr_q;
  logic [TAG_WIDTH-1:0] tag_sr_q [LATENCY];
  logic                 s_fire_s;
  logic                 m_fire_s;
  logic [RES_W-1:0]     res_s;
  logic [ENT_W-1:0]     wr_data_s;
  logic [ENT_W-1:0]     rd_data_s;

  assign s_ready  = s_ready_q;
  assign s_fire_s = s_valid & s_ready_q;
  assign m_fire_s = m_valid & m_ready;
  assign core_in  = s_data;
  // The top stage marks a finished result on core_out; the core needs no edge for it.
  assign core_ce  = s_fire_s | (|vld_sr_q[LATENCY-2:0]);

  always_comb begin
    cnt_d = cnt_q;
    if (s_fire_s && !m_fire_s) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (!s_fire_s && m_fire_s) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      s_ready_q <= (cnt_d < CNT_W'(FIFO_DEPTH));
    end
  end

  // With ce low every lower stage is already empty, so clearing drains the top stage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_sr_q  <= '0;
      div0_sr_q <= '0;
      for (int i = 0; i < LATENCY; i++) tag_sr_q[i] <= '0;
    end else if (core_ce) begin
      vld_sr_q    <= {vld_sr_q[LATENCY-2:0], s_fire_s};
      div0_sr_q   <= {div0_sr_q[LATENCY-2:0], (s_data == '0)};
      tag_sr_q[0] <= s_tag;
      for (int i = 1; i < LATENCY; i++) tag_sr_q[i] <= tag_sr_q[i-1];
    end else begin
      vld_sr_q <= '0;
    end
  end

  assign res_s     = div0_sr_q[LATENCY-1] ? {RES_W{1'b1}} : core_out;
  assign wr_data_s = {res_s, tag_sr_q[LATENCY-1], div0_sr_q[LATENCY-1]};

  recip_result_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .wr_en_i    (vld_sr_q[LATENCY-1]),
    .wr_data_i  (wr_data_s),
    .rd_en_i    (m_fire_s),
    .rd_valid_o (m_valid),
    .rd_data_o  (rd_data_s)
  );

  assign {m_data, m_tag, m_div0} = rd_data_s;

endmodule

// File: tb/tb_recip_stream_ctrl.sv
// Self-checking bench for recip_stream_ctrl with an exact-reciprocal core stub
// and a queue-based reference of the accepted items.
module tb_recip_stream_ctrl;

  localparam int NW  = 24;
  localparam int LAT = 13;
  localparam int TW  = 8;
  localparam int FD  = 16;
  localparam int EW  = 2*NW + TW + 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [NW-1:0] s_data = '0;
  logic [TW-1:0] s_tag = '0;
  logic          core_ce;
  logic [NW-1:0] core_in;
  logic [2*NW-1:0] core_out;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [2*NW-1:0] m_data;
  logic [TW-1:0] m_tag;
  logic          m_div0;

  always #5 clk = ~clk;

  recip_stream_ctrl #(
    .NUMBER_WIDTH (NW), .LATENCY (LAT), .TAG_WIDTH (TW), .FIFO_DEPTH (FD)
  ) dut (
    .clk (clk), .resetn (resetn),
    .s_valid (s_valid), .s_ready (s_ready), .s_data (s_data), .s_tag (s_tag),
    .core_ce (core_ce), .core_in (core_in), .core_out (core_out),
    .m_valid (m_valid), .m_ready (m_ready), .m_data (m_data), .m_tag (m_tag), .m_div0 (m_div0)
  );

  // Core stub: LAT ce-gated stages; a zero operand yields junk that must be overridden.
  logic [2*NW-1:0] stub_q [LAT];
  always @(posedge clk) begin
    if (core_ce) begin
      stub_q[0] <= (core_in == '0) ? 48'hDEADBEEFCAFE : (48'h000001000000 / {24'd0, core_in});
      for (int i = 1; i < LAT; i++) stub_q[i] <= stub_q[i-1];
    end
  end
  assign core_out = stub_q[LAT-1];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int n_in = 0;
  int n_out = 0;
  logic obs_s_ready, obs_m_valid, obs_ce, obs_s_fire, obs_m_fire, exp_none;
  logic [EW-1:0] obs_out, exp_out;
  logic [EW-1:0] exp_q [$];

  function automatic logic [EW-1:0] ref_item(input logic [NW-1:0] x, input logic [TW-1:0] tag);
    logic [95:0] q;
    if (x == '0) return {{(2*NW){1'b1}}, tag, 1'b1};
    q = (96'd1 << (2*NW - 1)) / {72'd0, x};
    q = q >> (NW - 1);
    return {q[2*NW-1:0], tag, 1'b0};
  endfunction

  task automatic step();
    #1;
    obs_s_ready = s_ready;
    obs_m_valid = m_valid;
    obs_ce      = core_ce;
    obs_s_fire  = s_valid & s_ready;
    obs_m_fire  = m_valid & m_ready;
    obs_out     = {m_data, m_tag, m_div0};
    exp_none    = 1'b0;
    if (obs_s_fire) begin
      exp_q.push_back(ref_item(s_data, s_tag));
      n_in++;
    end
    if (obs_m_fire) begin
      n_out++;
      if (exp_q.size() == 0) exp_none = 1'b1;
      else exp_out = exp_q.pop_front();
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    resetn = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    repeat (3) step();
    compared++;
    if ({obs_s_ready, obs_m_valid, obs_ce} !== 3'b000) begin
      mismatched++; $display("FAIL reset_ctrl: got ready/valid/ce=%b expected 000", {obs_s_ready, obs_m_valid, obs_ce});
    end
    compared++;
    if (obs_out !== '0) begin
      mismatched++; $display("FAIL reset_data: got %h expected 0", obs_out);
    end
    compared++;
    if (dut.cnt_q !== '0) begin
      mismatched++; $display("FAIL reset_cnt: got %0d expected 0", dut.cnt_q);
    end
    resetn = 1'b1;
    step();
    step();
    compared++;
    if (obs_s_ready !== 1'b1) begin
      mismatched++; $display("FAIL reset_release_ready: got %b expected 1", obs_s_ready);
    end
  endtask

  task automatic test_single();
    int c0;
    int lat;
    bit seen;
    m_ready = 1'b1; s_valid = 1'b1; s_data = 24'd4; s_tag = 8'h11;
    step();
    c0 = cyc - 1;
    compared++;
    if (obs_s_fire !== 1'b1) begin
      mismatched++; $display("FAIL single_accept: got %b expected 1", obs_s_fire);
    end
    s_valid = 1'b0;
    seen = 1'b0; lat = -1;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      if (obs_m_valid) begin
        seen = 1'b1;
        lat = cyc - 1 - c0;
        compared++;
        if (exp_none || obs_out !== exp_out) begin
          mismatched++; $display("FAIL single_out: got %h expected %h", obs_out, exp_out);
        end
      end
    end
    compared++;
    if (lat != LAT) begin
      mismatched++; $display("FAIL single_latency: got %0d expected %0d", lat, LAT);
    end
    compared++;
    if (obs_out !== {48'h000000400000, 8'h11, 1'b0}) begin
      mismatched++; $display("FAIL single_value: got %h expected %h", obs_out, {48'h000000400000, 8'h11, 1'b0});
    end
    repeat (5) step();
  endtask

  task automatic test_stream();
    int first_out;
    int last_out;
    int outs;
    first_out = -1; last_out = -1; outs = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 130; i++) begin
      s_valid = (i < 100);
      s_data  = NW'($urandom);
      s_tag   = TW'($urandom);
      step();
      if (i < 100) begin
        compared++;
        if (obs_s_ready !== 1'b1 || obs_ce !== 1'b1) begin
          mismatched++; $display("FAIL stream_ready_ce: got ready=%b ce=%b expected 1/1", obs_s_ready, obs_ce);
        end
      end
      if (obs_m_fire) begin
        compared++;
        if (exp_none || obs_out !== exp_out) begin
          mismatched++; $display("FAIL stream_out: got %h expected %h", obs_out, exp_out);
        end
        outs++;
        if (first_out < 0) first_out = cyc - 1;
        last_out = cyc - 1;
      end
    end
    compared++;
    if (outs != 100 || last_out - first_out != 99) begin
      mismatched++; $display("FAIL stream_count: got %0d items over %0d cycles expected 100 over 99", outs, last_out - first_out);
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int first_fire;
    bit checked;
    int in0;
    int out0;
    acc = 0; first_fire = -1; checked = 1'b0; in0 = n_in; out0 = n_out;
    m_ready = 1'b0; s_valid = 1'b1; s_data = NW'($urandom); s_tag = TW'($urandom);
    for (int i = 0; i < 30; i++) begin
      step();
      if (obs_s_fire) begin
        acc++; s_data = NW'($urandom); s_tag = TW'($urandom);
      end
    end
    compared++;
    if (acc != FD || obs_s_ready !== 1'b0) begin
      mismatched++; $display("FAIL bp_accept: got %0d accepted ready=%b expected %0d ready=0", acc, obs_s_ready, FD);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 52; i++) begin
      s_valid = (i < 12);
      step();
      if (obs_m_fire) begin
        compared++;
        if (exp_none || obs_out !== exp_out) begin
          mismatched++; $display("FAIL bp_out: got %h expected %h", obs_out, exp_out);
        end
      end
      if (first_fire >= 0 && !checked) begin
        checked = 1'b1;
        compared++;
        if (obs_s_ready !== 1'b1) begin
          mismatched++; $display("FAIL bp_ready_return: got %b expected 1", obs_s_ready);
        end
      end
      if (obs_m_fire && first_fire < 0) begin
        first_fire = cyc - 1;
        compared++;
        if (obs_s_ready !== 1'b0) begin
          mismatched++; $display("FAIL bp_ready_early: got %b expected 0", obs_s_ready);
        end
      end
      if (obs_s_fire) begin
        s_data = NW'($urandom); s_tag = TW'($urandom);
      end
    end
    compared++;
    if (exp_q.size() != 0 || (n_in - in0) != (n_out - out0)) begin
      mismatched++; $display("FAIL bp_conserve: got in=%0d out=%0d left=%0d expected equal and 0 left", n_in - in0, n_out - out0, exp_q.size());
    end
  endtask

  task automatic test_div0();
    logic [NW-1:0] ops [3];
    logic [TW-1:0] tags [3];
    bit seen_z;
    ops[0] = 24'd7; ops[1] = 24'd0; ops[2] = 24'd9;
    tags[0] = 8'h01; tags[1] = 8'h5A; tags[2] = 8'h02;
    seen_z = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 28; i++) begin
      s_valid = (i < 3);
      if (i < 3) begin
        s_data = ops[i]; s_tag = tags[i];
      end
      step();
      if (obs_m_fire) begin
        compared++;
        if (exp_none || obs_out !== exp_out) begin
          mismatched++; $display("FAIL div0_out: got %h expected %h", obs_out, exp_out);
        end
        if (obs_out[TW:1] == 8'h5A) begin
          seen_z = 1'b1;
          compared++;
          if (obs_out !== {48'hFFFFFFFFFFFF, 8'h5A, 1'b1}) begin
            mismatched++; $display("FAIL div0_value: got %h expected %h", obs_out, {48'hFFFFFFFFFFFF, 8'h5A, 1'b1});
          end
        end
      end
    end
    compared++;
    if (!seen_z) begin
      mismatched++; $display("FAIL div0_seen: got no item tagged 5a expected one");
    end
  endtask

  task automatic test_idle();
    int ce_cnt;
    m_ready = 1'b1; s_valid = 1'b1; s_data = 24'd3; s_tag = 8'h33;
    step();
    ce_cnt = int'(obs_ce);
    s_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      ce_cnt += int'(obs_ce);
      if (obs_m_fire) begin
        compared++;
        if (exp_none || obs_out !== exp_out) begin
          mismatched++; $display("FAIL idle_out: got %h expected %h", obs_out, exp_out);
        end
      end
    end
    compared++;
    if (ce_cnt != LAT || obs_ce !== 1'b0) begin
      mismatched++; $display("FAIL idle_ce_count: got %0d cycles final=%b expected %0d final=0", ce_cnt, obs_ce, LAT);
    end
    s_valid = 1'b1; s_data = 24'd5; s_tag = 8'h44;
    step();
    compared++;
    if (obs_ce !== 1'b1) begin
      mismatched++; $display("FAIL idle_reenable: got %b expected 1", obs_ce);
    end
    s_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (obs_m_fire) begin
        compared++;
        if (exp_none || obs_out !== exp_out) begin
          mismatched++; $display("FAIL idle_out2: got %h expected %h", obs_out, exp_out);
        end
      end
    end
  endtask

  task automatic test_reset_flight();
    m_ready = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 13; i++) begin
      s_data = NW'($urandom); s_tag = TW'($urandom);
      step();
    end
    s_valid = 1'b0;
    repeat (3) step();
    compared++;
    if (obs_m_valid !== 1'b1) begin
      mismatched++; $display("FAIL rst_pre_buffered: got %b expected 1", obs_m_valid);
    end
    resetn = 1'b0;
    exp_q.delete();
    step();
    compared++;
    if (obs_m_valid !== 1'b0 || dut.cnt_q !== '0 || obs_s_ready !== 1'b0) begin
      mismatched++; $display("FAIL rst_mid: got valid=%b cnt=%0d ready=%b expected 0/0/0", obs_m_valid, dut.cnt_q, obs_s_ready);
    end
    step();
    resetn = 1'b1; m_ready = 1'b1;
    step();
    step();
    compared++;
    if (obs_s_ready !== 1'b1) begin
      mismatched++; $display("FAIL rst_release_ready: got %b expected 1", obs_s_ready);
    end
    for (int i = 0; i < 2*LAT; i++) begin
      step();
      compared++;
      if (obs_m_valid !== 1'b0) begin
        mismatched++; $display("FAIL rst_stale: got m_valid=%b expected 0 at step %0d", obs_m_valid, i);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_div0();
    test_idle();
    test_reset_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
